// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
//
// Shares one downstream val/rdy memory port between NUM_PORTS requesters
// (e.g. a core's imem/dmem ports, or several cores). Requests pass straight
// through to memory with no buffering. A round-robin pointer picks the
// winner. The grant is locked while memory stalls, so a presented request
// never changes under a valid. Every accepted request pushes its port ID
// into a small FIFO. Because memory answers in order, the head of that FIFO
// names the requester for each returning response.
//
// Message formats follow the VC memory messages:
//   request  = {type, addr[ADDR_SZ], len[clog2(DATA_SZ/8)], data[DATA_SZ]}
//   response = {type, len[clog2(DATA_SZ/8)], data[DATA_SZ]}
//
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   req_msg      packed requests, port i at [i*REQ_SZ +: REQ_SZ]
//   req_val      per-port request valid
//   req_rdy      per-port request accepted (only the winner, only on fire)
//   resp_msg     downstream response replicated on every slice
//   resp_val     one-hot (or zero) response valid
//   memreq_*     downstream request val/rdy port
//   memresp_*    downstream response (always accepted, no ready)
//   outstanding  number of requests awaiting a response
//   proto_err    sticky: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module riscv_mem_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_SZ         = 32,
  parameter int DATA_SZ         = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int LEN_SZ  = $clog2(DATA_SZ/8),
  localparam int REQ_SZ  = 1 + ADDR_SZ + LEN_SZ + DATA_SZ,
  localparam int RESP_SZ = 1 + LEN_SZ + DATA_SZ,
  localparam int PID_SZ  = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
  localparam int CNT_SZ  = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS*REQ_SZ-1:0]  req_msg,
  input  logic [NUM_PORTS-1:0]         req_val,
  output logic [NUM_PORTS-1:0]         req_rdy,
  output logic [NUM_PORTS*RESP_SZ-1:0] resp_msg,
  output logic [NUM_PORTS-1:0]         resp_val,
  output logic [REQ_SZ-1:0]            memreq_msg,
  output logic                         memreq_val,
  input  logic                         memreq_rdy,
  input  logic [RESP_SZ-1:0]           memresp_msg,
  input  logic                         memresp_val,
  output logic [CNT_SZ-1:0]            outstanding,
  output logic                         proto_err
);

  localparam int PTR_SZ = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [PID_SZ-1:0] rr_ptr;
  logic              lock_val;
  logic [PID_SZ-1:0] lock_pid;

  logic [PID_SZ-1:0] pid_fifo [MAX_OUTSTANDING];
  logic [PTR_SZ-1:0] head;
  logic [PTR_SZ-1:0] tail;
  logic [CNT_SZ-1:0] count;

  logic [PID_SZ-1:0] winner;
  logic [PID_SZ-1:0] scan_idx;
  logic              found;
  logic              any_sel;
  logic              full;
  logic              fire;
  logic              pop;
  logic              spurious;
  logic [PID_SZ-1:0] head_pid;

  // Winner selection: a locked grant wins outright; otherwise scan
  // upward from rr_ptr for the first valid port.
  always_comb begin
    winner   = '0;
    scan_idx = '0;
    found    = 1'b0;
    if (lock_val) begin
      winner = lock_pid;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        scan_idx = PID_SZ'((int'(rr_ptr) + k) % NUM_PORTS);
        if (!found && req_val[scan_idx]) begin
          winner = scan_idx;
          found  = 1'b1;
        end
      end
    end
  end

  assign any_sel    = lock_val | (|req_val);
  assign full       = (count == CNT_SZ'(MAX_OUTSTANDING));
  assign memreq_val = !reset & any_sel & !full;
  assign memreq_msg = req_msg[winner*REQ_SZ +: REQ_SZ];
  assign fire       = memreq_val & memreq_rdy;

  always_comb begin
    req_rdy = '0;
    if (fire) req_rdy[winner] = 1'b1;
  end

  // Response routing. A response with an empty FIFO cannot belong to a
  // request that fires in the same cycle (memory latency is at least one
  // cycle). So it is dropped and flagged instead of being matched.
  assign head_pid = pid_fifo[head];
  assign pop      = !reset & memresp_val & (count != '0);
  assign spurious = !reset & memresp_val & (count == '0);

  always_comb begin
    resp_val = '0;
    if (pop) resp_val[head_pid] = 1'b1;
  end

  assign resp_msg    = {NUM_PORTS{memresp_msg}};
  assign outstanding = count;

  // Control state: arbitration pointer, grant lock, FIFO pointers, error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      lock_val  <= 1'b0;
      lock_pid  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      if (fire) begin
        rr_ptr   <= (winner == PID_SZ'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
        lock_val <= 1'b0;
        tail     <= (tail == PTR_SZ'(MAX_OUTSTANDING - 1)) ? '0 : tail + 1'b1;
      end else if (memreq_val) begin
        // Stalled downstream: freeze the grant until it is accepted.
        lock_val <= 1'b1;
        lock_pid <= winner;
      end
      if (pop) begin
        head <= (head == PTR_SZ'(MAX_OUTSTANDING - 1)) ? '0 : head + 1'b1;
      end
      case ({fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (spurious) proto_err <= 1'b1;
    end
  end

  // Port-ID storage is data only; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (fire) pid_fifo[tail] <= winner;
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

  localparam int NP      = 2;
  localparam int REQ_SZ  = 67;   // 1 + 32 + 2 + 32
  localparam int RESP_SZ = 35;   // 1 + 2 + 32
  localparam int CNT_SZ  = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NP*REQ_SZ-1:0]   req_msg;
  logic [NP-1:0]          req_val;
  logic [NP-1:0]          req_rdy;
  logic [NP*RESP_SZ-1:0]  resp_msg;
  logic [NP-1:0]          resp_val;
  logic [REQ_SZ-1:0]      memreq_msg;
  logic                   memreq_val;
  logic                   memreq_rdy;
  logic [RESP_SZ-1:0]     memresp_msg;
  logic                   memresp_val;
  logic [CNT_SZ-1:0]      outstanding;
  logic                   proto_err;

  riscv_mem_arbiter #(
    .NUM_PORTS(NP), .ADDR_SZ(32), .DATA_SZ(32), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
    .resp_msg(resp_msg), .resp_val(resp_val),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [REQ_SZ-1:0] msg; int port; } req_exp_t;
  typedef struct { logic [RESP_SZ-1:0] msg; int port; } resp_exp_t;

  req_exp_t  req_q[$];
  resp_exp_t resp_q[$];

  int errors = 0;
  int checks = 0;

  function automatic logic [REQ_SZ-1:0] mkreq(logic [31:0] addr, logic [31:0] data);
    return {1'b0, addr, 2'd0, data};
  endfunction

  function automatic logic [RESP_SZ-1:0] mkresp(logic [31:0] data);
    return {1'b0, 2'd0, data};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int port, logic [31:0] addr);
    req_msg[port*REQ_SZ +: REQ_SZ] = mkreq(addr, 32'h0);
  endtask

  task automatic expect_req(int port, logic [31:0] addr);
    req_exp_t e;
    e.msg  = mkreq(addr, 32'h0);
    e.port = port;
    req_q.push_back(e);
  endtask

  // Acts as memory: present one response for one cycle and record where
  // it must be routed.
  task automatic send_resp(int port, logic [31:0] data);
    resp_exp_t e;
    e.msg  = mkresp(data);
    e.port = port;
    resp_q.push_back(e);
    memresp_msg = mkresp(data);
    memresp_val = 1'b1;
    tick();
    memresp_val = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: compares every accepted downstream request and every routed
  // response against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset && memreq_val && memreq_rdy) begin
      if (req_q.size() == 0) begin
        check("unexpected_memreq", {61'h0, memreq_msg}, 128'h0);
      end else begin
        req_exp_t e;
        e = req_q.pop_front();
        check("memreq_msg", {61'h0, memreq_msg}, {61'h0, e.msg});
        check("req_rdy", {126'h0, req_rdy}, 128'(1) << e.port);
      end
    end
    if (resp_val != '0) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp_val", {126'h0, resp_val}, 128'h0);
      end else begin
        resp_exp_t e;
        e = resp_q.pop_front();
        check("resp_val", {126'h0, resp_val}, 128'(1) << e.port);
        check("resp_msg", {58'h0, resp_msg}, {58'h0, e.msg, e.msg});
      end
    end
  end

  initial begin
    reset       = 1'b1;
    req_msg     = '0;
    req_val     = 2'b11;
    memreq_rdy  = 1'b1;
    memresp_msg = mkresp(32'h1234);
    memresp_val = 1'b1;
    #1;
    // Outputs gated while reset is held, even with live inputs.
    check("rst_memreq_val", {127'h0, memreq_val}, 128'h0);
    check("rst_req_rdy", {126'h0, req_rdy}, 128'h0);
    check("rst_resp_val", {126'h0, resp_val}, 128'h0);
    check("rst_outstanding", {125'h0, outstanding}, 128'h0);
    check("rst_proto_err", {127'h0, proto_err}, 128'h0);
    req_val     = '0;
    memresp_val = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Single request, response two cycles later.
    set_req(0, 32'h100);
    expect_req(0, 32'h100);
    req_val = 2'b01;
    tick();
    req_val = '0;
    check("single_outstanding1", {125'h0, outstanding}, 128'd1);
    tick();
    send_resp(0, 32'hDEADBEEF);
    check("single_outstanding0", {125'h0, outstanding}, 128'd0);

    // Contention: both ports valid for four cycles alternate p0,p1,p0,p1.
    do_reset();
    set_req(0, 32'h200);
    set_req(1, 32'h300);
    expect_req(0, 32'h200);
    expect_req(1, 32'h300);
    expect_req(0, 32'h200);
    expect_req(1, 32'h300);
    req_val = 2'b11;
    repeat (4) tick();
    req_val = '0;
    check("cont_outstanding4", {125'h0, outstanding}, 128'd4);
    send_resp(0, 32'hA0);
    send_resp(1, 32'hA1);
    send_resp(0, 32'hA2);
    send_resp(1, 32'hA3);
    check("cont_outstanding0", {125'h0, outstanding}, 128'd0);

    // Backpressure: p1 stalls, p0 arrives late and must not steal the grant.
    set_req(1, 32'h400);
    set_req(0, 32'h500);
    expect_req(1, 32'h400);
    expect_req(0, 32'h500);
    memreq_rdy = 1'b0;
    req_val    = 2'b10;
    #1;
    check("bp_msg_c0", {61'h0, memreq_msg}, {61'h0, mkreq(32'h400, 32'h0)});
    tick();
    req_val = 2'b11;
    #1;
    check("bp_msg_c1", {61'h0, memreq_msg}, {61'h0, mkreq(32'h400, 32'h0)});
    check("bp_val_c1", {127'h0, memreq_val}, 128'd1);
    tick();
    #1;
    check("bp_msg_c2", {61'h0, memreq_msg}, {61'h0, mkreq(32'h400, 32'h0)});
    tick();
    memreq_rdy = 1'b1;
    tick();
    req_val = 2'b01;
    tick();
    req_val = '0;
    check("bp_outstanding2", {125'h0, outstanding}, 128'd2);
    send_resp(1, 32'hC1);
    send_resp(0, 32'hC0);

    // Full: four accepted, fifth blocked, no bypass on a same-cycle pop.
    do_reset();
    set_req(0, 32'h600);
    repeat (5) expect_req(0, 32'h600);
    req_val = 2'b01;
    repeat (4) tick();
    check("full_outstanding4", {125'h0, outstanding}, 128'd4);
    check("full_blocked", {127'h0, memreq_val}, 128'd0);
    resp_q.push_back('{msg: mkresp(32'hB0), port: 0});
    memresp_msg = mkresp(32'hB0);
    memresp_val = 1'b1;
    #1;
    check("full_no_bypass", {127'h0, memreq_val}, 128'd0);
    tick();
    memresp_val = 1'b0;
    #1;
    check("full_push_next", {127'h0, memreq_val}, 128'd1);
    tick();
    req_val = '0;
    check("full_outstanding_again", {125'h0, outstanding}, 128'd4);
    send_resp(0, 32'hB1);
    send_resp(0, 32'hB2);
    send_resp(0, 32'hB3);
    send_resp(0, 32'hB4);
    check("full_drained", {125'h0, outstanding}, 128'd0);

    // Spurious response with nothing outstanding.
    memresp_msg = mkresp(32'hBAD);
    memresp_val = 1'b1;
    #1;
    check("spur_resp_val", {126'h0, resp_val}, 128'h0);
    tick();
    memresp_val = 1'b0;
    check("spur_proto_err", {127'h0, proto_err}, 128'd1);
    check("spur_outstanding", {125'h0, outstanding}, 128'd0);
    repeat (3) tick();
    check("spur_sticky", {127'h0, proto_err}, 128'd1);

    // Async reset mid-stream with three outstanding; rr_ptr is left at 1.
    set_req(0, 32'h700);
    repeat (3) expect_req(0, 32'h700);
    req_val = 2'b01;
    repeat (3) tick();
    req_val = '0;
    check("ar_outstanding3", {125'h0, outstanding}, 128'd3);
    set_req(0, 32'h900);
    set_req(1, 32'hA00);
    req_val = 2'b11;
    #2;
    reset = 1'b1;
    #1;
    check("ar_outstanding0", {125'h0, outstanding}, 128'd0);
    check("ar_proto_err0", {127'h0, proto_err}, 128'd0);
    check("ar_memreq_val0", {127'h0, memreq_val}, 128'd0);
    check("ar_req_rdy0", {126'h0, req_rdy}, 128'd0);
    tick();
    tick();
    expect_req(0, 32'h900);
    reset = 1'b0;
    tick();
    req_val = '0;
    send_resp(0, 32'hE0);
    check("ar_final_outstanding", {125'h0, outstanding}, 128'd0);
    check("ar_proto_err_clear", {127'h0, proto_err}, 128'd0);

    tick();
    check("req_queue_empty", 128'(req_q.size()), 128'd0);
    check("resp_queue_empty", 128'(resp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Parametrised N-port memory request arbiter with in-order response routing.
- Lets several requesters share one downstream val/rdy memory port: a core's imem and dmem ports, or multiple cores.
- Uses the existing VC memory request/response message formats.
- Tracks outstanding requests in a port-ID FIFO so each in-order memory response returns to its originator.

Parameters:
- NUM_PORTS, 2, number of requester ports (>=2).
- ADDR_SZ, 32, request address width.
- DATA_SZ, 32, data width; must be a multiple of 8.
- MAX_OUTSTANDING, 4, depth of the port-ID FIFO (power of 2, >=1).
- Derived: REQ_SZ = VC_MEM_REQ_MSG_SZ(ADDR_SZ,DATA_SZ), RESP_SZ = VC_MEM_RESP_MSG_SZ(DATA_SZ), PID_SZ = max(1,clog2(NUM_PORTS)), CNT_SZ = clog2(MAX_OUTSTANDING)+1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_msg  in  NUM_PORTS*REQ_SZ  packed requests; port i occupies bits [i*REQ_SZ +: REQ_SZ].
- req_val  in  NUM_PORTS  request valid per port.
- req_rdy  out  NUM_PORTS  request accepted per port.
- resp_msg  out  NUM_PORTS*RESP_SZ  response message; the same value is driven on every slice.
- resp_val  out  NUM_PORTS  response valid, one-hot or zero.
- memreq_msg  out  REQ_SZ  downstream request.
- memreq_val  out  1  downstream request valid.
- memreq_rdy  in  1  downstream ready.
- memresp_msg  in  RESP_SZ  downstream response.
- memresp_val  in  1  downstream response valid. No ready: responses are always accepted.
- outstanding  out  CNT_SZ  current FIFO occupancy.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, active-high) clears:
  - rr_ptr=0, lock_val=0, lock_pid=0;
  - FIFO head, tail and count = 0;
  - proto_err=0.
- While reset is asserted: memreq_val=0, req_rdy=0, resp_val=0, outstanding=0.
- Arbitration (combinational):
  - If lock_val, winner = lock_pid.
  - Otherwise winner = first i with req_val[i], scanning from rr_ptr upward, modulo NUM_PORTS.
- full = (count == MAX_OUTSTANDING).
- Downstream request:
  - memreq_val = any_sel & !full, where any_sel = (lock_val | |req_val).
  - memreq_msg = req_msg slice of the winner.
- req_rdy[i] = memreq_val & memreq_rdy & (i == winner). Zero-cycle pass-through; no request buffering.
- fire = memreq_val & memreq_rdy. On fire:
  - push winner into the FIFO tail;
  - rr_ptr <= (winner+1) mod NUM_PORTS;
  - lock_val <= 0.
- Grant lock:
  - If memreq_val & !memreq_rdy, then lock_val<=1 and lock_pid<=winner.
  - The grant cannot change while downstream stalls.
  - Requesters must hold req_val and msg stable until req_rdy, per val/rdy rules.
- Full: memreq_val=0 and no push, even if memresp_val pops in the same cycle (no full bypass). The lock is kept.
- Response routing:
  - When memresp_val and count>0: pop the head; resp_val[head_pid]=1 in the same cycle (combinational, 0 latency); all other resp_val bits = 0.
  - Every slice of resp_msg = memresp_msg.
- Push and pop in the same cycle with count>0 and not full: count is unchanged, both pointers advance.
- memresp_val with count==0 is an error:
  - set proto_err (sticky until reset);
  - drop the response, all resp_val=0;
  - count stays 0.
  - A request firing in the same cycle does not satisfy it; memory latency is >=1 cycle.
- FIFO pointers wrap modulo MAX_OUTSTANDING. count saturates nowhere; full blocks push and the error path blocks underflow.
- Reset mid-operation discards all tracked IDs. Responses arriving afterward for pre-reset requests raise proto_err, so memory must be reset together with the arbiter.
- outstanding = count, registered.

Test Plan:
- Single request: port0 read addr 0x100, memreq_rdy=1, response after 2 cycles with data 0xDEADBEEF -> req_rdy=01 in cycle 0, outstanding 1, then resp_val=01 with data 0xDEADBEEF, outstanding 0.
- Contention, NUM_PORTS=2: both ports hold req_val for 4 cycles, memreq_rdy=1 -> memreq addresses alternate p0,p1,p0,p1; responses return in order and route as resp_val=01,10,01,10.
- Backpressure lock: p1 valid, memreq_rdy=0 for 3 cycles, p0 asserts req_val in cycle 1 -> memreq_msg stays p1 every cycle; p1 fires first when rdy=1, p0 fires next cycle.
- Full, MAX_OUTSTANDING=4: 4 accepted with no responses -> outstanding=4, memreq_val=0 while a 5th is pending; one memresp that cycle -> still no push that cycle, push next cycle, outstanding=4.
- Spurious response: memresp_val with outstanding=0 -> proto_err=1, resp_val=0, outstanding stays 0; proto_err stays 1 until reset.
- Async reset mid-stream with outstanding=3 -> outstanding, proto_err and rr_ptr go to 0 immediately without a clock edge; first grant after reset goes to port0 when all ports are valid.
